// File: rtl/ps2_message_assembler_if.sv
// PS/2 message assembler bus: key byte in, send ack in,
// assembled message and LCD echo out.
interface ps2_message_assembler_if;
  logic         key_valid;
  logic [7:0]   key_code;
  logic         send_done;
  logic [127:0] message_out;
  logic         message_ready;
  logic [4:0]   char_count;
  logic [7:0]   ascii_out;
  logic         ascii_valid;

  modport master (
    output key_valid, key_code, send_done,
    input  message_out, message_ready, char_count,
    input  ascii_out, ascii_valid
  );

  modport slave (
    input  key_valid, key_code, send_done,
    output message_out, message_ready, char_count,
    output ascii_out, ascii_valid
  );
endinterface

// File: rtl/ps2_message_assembler.sv
// Collects PS/2 set-2 key presses into a 16-char
// ASCII message held until the link acknowledges it.
module ps2_message_assembler #(
  parameter bit SEND_ON_FULL = 1'b1
) (
  input logic clock,
  input logic reset,
  ps2_message_assembler_if.slave bus
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t       state, state_n;
  logic         brk, brk_n;
  logic         ext, ext_n;
  logic [127:0] msg, msg_n;
  logic [4:0]   cnt, cnt_n;
  logic [7:0]   asc, asc_n;
  logic         av, av_n;

  logic [7:0]   chr;
  logic         is_bs;
  logic         is_ent;
  logic         live;
  logic [3:0]   idx;

  // scan byte to ASCII; chr==0 means not printable
  always_comb begin
    chr    = 8'd0;
    is_bs  = (bus.key_code == 8'h66);
    is_ent = (bus.key_code == 8'h5A);
    case (bus.key_code)
      8'h1C: chr = 8'd97;
      8'h32: chr = 8'd98;
      8'h21: chr = 8'd99;
      8'h23: chr = 8'd100;
      8'h24: chr = 8'd101;
      8'h2B: chr = 8'd102;
      8'h34: chr = 8'd103;
      8'h33: chr = 8'd104;
      8'h43: chr = 8'd105;
      8'h3B: chr = 8'd106;
      8'h42: chr = 8'd107;
      8'h4B: chr = 8'd108;
      8'h3A: chr = 8'd109;
      8'h31: chr = 8'd110;
      8'h44: chr = 8'd111;
      8'h4D: chr = 8'd112;
      8'h15: chr = 8'd113;
      8'h2D: chr = 8'd114;
      8'h1B: chr = 8'd115;
      8'h2C: chr = 8'd116;
      8'h3C: chr = 8'd117;
      8'h2A: chr = 8'd118;
      8'h1D: chr = 8'd119;
      8'h22: chr = 8'd120;
      8'h35: chr = 8'd121;
      8'h1A: chr = 8'd122;
      8'h29: chr = 8'd32;
      default: chr = 8'd0;
    endcase
  end

  // prefix tracking, buffer edits and state transitions
  always_comb begin
    state_n = state;
    brk_n   = brk;
    ext_n   = ext;
    msg_n   = msg;
    cnt_n   = cnt;
    asc_n   = asc;
    av_n    = 1'b0;
    live    = 1'b0;
    idx     = cnt[3:0];

    if (bus.key_valid) begin
      if (bus.key_code == 8'hF0) begin
        brk_n = 1'b1;
      end else if (bus.key_code == 8'hE0) begin
        ext_n = 1'b1;
      end else begin
        // byte after a prefix belongs to a release
        // or extended key and is swallowed
        live  = !(brk || ext);
        brk_n = 1'b0;
        ext_n = 1'b0;
      end
    end

    case (state)
      COLLECT: begin
        if (live) begin
          unique case (1'b1)
            (chr != 8'd0): begin
              if (!cnt[4]) begin
                msg_n[{~idx, 3'b000} +: 8] = chr;
                cnt_n = cnt + 5'd1;
                asc_n = chr;
                av_n  = 1'b1;
                if (SEND_ON_FULL && cnt == 5'd15)
                  state_n = HOLD;
              end
            end
            is_bs: begin
              if (cnt != 5'd0) begin
                idx = cnt[3:0] - 4'd1;
                msg_n[{~idx, 3'b000} +: 8] = 8'd0;
                cnt_n = cnt - 5'd1;
                asc_n = 8'd127;
                av_n  = 1'b1;
              end
            end
            is_ent: begin
              if (cnt != 5'd0)
                state_n = HOLD;
            end
            default: ;
          endcase
        end
      end
      HOLD: begin
        if (bus.send_done) begin
          msg_n   = 128'd0;
          cnt_n   = 5'd0;
          state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= COLLECT;
      brk   <= 1'b0;
      ext   <= 1'b0;
      msg   <= 128'd0;
      cnt   <= 5'd0;
      asc   <= 8'd0;
      av    <= 1'b0;
    end else begin
      state <= state_n;
      brk   <= brk_n;
      ext   <= ext_n;
      msg   <= msg_n;
      cnt   <= cnt_n;
      asc   <= asc_n;
      av    <= av_n;
    end
  end

  assign bus.message_out   = msg;
  assign bus.message_ready = (state == HOLD);
  assign bus.char_count    = cnt;
  assign bus.ascii_out     = asc;
  assign bus.ascii_valid   = av;

endmodule

// File: tb/tb_ps2_message_assembler.sv
// Scoreboard bench for ps2_message_assembler:
// directed scan-byte sequences, LCD strobes checked by a monitor.
module tb_ps2_message_assembler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_message_assembler_if bus0();
  ps2_message_assembler_if bus1();

  ps2_message_assembler #(.SEND_ON_FULL(1'b1)) dut0 (
    .clock(clk), .reset(rst), .bus(bus0)
  );

  ps2_message_assembler #(.SEND_ON_FULL(1'b0)) dut1 (
    .clock(clk), .reset(rst), .bus(bus1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_str1 = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: every LCD strobe must match the next queued char
  always @(negedge clk) begin
    if (bus0.ascii_valid === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ascii_strobe: unexpected char %0d, none expected",
                 bus0.ascii_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus0.ascii_out !== e) begin
          n_fail++;
          $display("FAIL ascii_out: got %0d expected %0d",
                   bus0.ascii_out, e);
        end
      end
    end
    if (bus1.ascii_valid === 1'b1) n_str1++;
  end

  task automatic send(input bit s, input logic [7:0] b);
    if (s) begin
      bus1.key_valid = 1'b1;
      bus1.key_code  = b;
    end else begin
      bus0.key_valid = 1'b1;
      bus0.key_code  = b;
    end
    @(posedge clk); #1;
    bus0.key_valid = 1'b0;
    bus1.key_valid = 1'b0;
  endtask

  task automatic done(input bit s);
    if (s) bus1.send_done = 1'b1;
    else   bus0.send_done = 1'b1;
    @(posedge clk); #1;
    bus0.send_done = 1'b0;
    bus1.send_done = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] b);
    rst = 1'b1;
    bus0.key_valid = 1'b1;
    bus0.key_code  = b;
    bus0.send_done = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus0.key_valid = 1'b0;
    bus0.send_done = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".msg"}, bus0.message_out, 128'd0);
    chk({nm, ".cnt"}, 128'(bus0.char_count), 128'd0);
    chk({nm, ".rdy"}, 128'(bus0.message_ready), 128'd0);
    chk({nm, ".asc"}, 128'(bus0.ascii_out), 128'd0);
    chk({nm, ".av"}, 128'(bus0.ascii_valid), 128'd0);
  endtask

  logic [7:0] seq28 [7] = '{8'h1C, 8'hF0, 8'h1C, 8'h32,
                            8'hF0, 8'h32, 8'h5A};
  logic [7:0] seq31 [6] = '{8'hE0, 8'h75, 8'hE0, 8'hF0,
                            8'h75, 8'h5A};

  initial begin
    bus0.key_valid = 1'b0; bus0.key_code = 8'h00;
    bus0.send_done = 1'b0;
    bus1.key_valid = 1'b0; bus1.key_code = 8'h00;
    bus1.send_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // break codes and prefixed bytes are swallowed
    exp_q.push_back(8'd97);
    exp_q.push_back(8'd98);
    foreach (seq28[i]) send(1'b0, seq28[i]);
    chk("ab.msg", bus0.message_out, {8'd97, 8'd98, 112'd0});
    chk("ab.cnt", 128'(bus0.char_count), 128'd2);
    chk("ab.rdy", 128'(bus0.message_ready), 128'd1);
    send(1'b0, 8'h1C);
    chk("hold.ign", bus0.message_out, {8'd97, 8'd98, 112'd0});
    done(1'b0);
    chk("sent.msg", bus0.message_out, 128'd0);
    chk("sent.cnt", 128'(bus0.char_count), 128'd0);
    chk("sent.rdy", 128'(bus0.message_ready), 128'd0);

    // backspace, then backspace on empty buffer
    exp_q.push_back(8'd97);
    exp_q.push_back(8'd127);
    exp_q.push_back(8'd122);
    send(1'b0, 8'h1C);
    send(1'b0, 8'h66);
    chk("bs.cnt", 128'(bus0.char_count), 128'd0);
    send(1'b0, 8'h66);
    send(1'b0, 8'h1A);
    chk("bs.msg", bus0.message_out, {8'd122, 120'd0});
    chk("bs.cnt1", 128'(bus0.char_count), 128'd1);
    exp_q.push_back(8'd127);
    send(1'b0, 8'h66);

    // extended keys and enter on empty buffer do nothing
    foreach (seq31[i]) send(1'b0, seq31[i]);
    chk("ext.cnt", 128'(bus0.char_count), 128'd0);
    chk("ext.rdy", 128'(bus0.message_ready), 128'd0);
    chk("ext.msg", bus0.message_out, 128'd0);

    // sixteen spaces auto-submit
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'd32);
      send(1'b0, 8'h29);
      if (i == 14)
        chk("full15.rdy", 128'(bus0.message_ready), 128'd0);
    end
    chk("full.rdy", 128'(bus0.message_ready), 128'd1);
    chk("full.msg", bus0.message_out, {16{8'h20}});
    chk("full.cnt", 128'(bus0.char_count), 128'd16);
    send(1'b0, 8'h29);
    chk("full17.cnt", 128'(bus0.char_count), 128'd16);
    chk("full17.msg", bus0.message_out, {16{8'h20}});
    done(1'b0);
    chk("fsent.msg", bus0.message_out, 128'd0);
    chk("fsent.rdy", 128'(bus0.message_ready), 128'd0);

    // send_done beats a same-cycle key in HOLD
    exp_q.push_back(8'd97);
    send(1'b0, 8'h1C);
    send(1'b0, 8'h5A);
    chk("col.rdy", 128'(bus0.message_ready), 128'd1);
    bus0.send_done = 1'b1;
    send(1'b0, 8'h1C);
    bus0.send_done = 1'b0;
    chk("col.cnt", 128'(bus0.char_count), 128'd0);
    chk("col.msg", bus0.message_out, 128'd0);
    chk("col.rdy0", 128'(bus0.message_ready), 128'd0);

    // reset mid-message
    exp_q.push_back(8'd97);
    exp_q.push_back(8'd98);
    exp_q.push_back(8'd99);
    exp_q.push_back(8'd100);
    exp_q.push_back(8'd101);
    send(1'b0, 8'h1C); send(1'b0, 8'h32); send(1'b0, 8'h21);
    send(1'b0, 8'h23); send(1'b0, 8'h24);
    chk("five.cnt", 128'(bus0.char_count), 128'd5);
    do_reset(8'h1C);
    chk_zero("rst5");
    exp_q.push_back(8'd97);
    send(1'b0, 8'h1C);
    chk("rst5.a", bus0.message_out, {8'd97, 120'd0});

    // reset in HOLD, with a pending break prefix
    send(1'b0, 8'h5A);
    chk("rsth.rdy", 128'(bus0.message_ready), 128'd1);
    send(1'b0, 8'hF0);
    do_reset(8'hE0);
    chk_zero("rsth");
    exp_q.push_back(8'd97);
    send(1'b0, 8'h1C);
    chk("rsth.a", bus0.message_out, {8'd97, 120'd0});
    chk("rsth.cnt", 128'(bus0.char_count), 128'd1);

    // no auto-submit: seventeenth char dropped silently
    for (int i = 0; i < 17; i++) send(1'b1, 8'h29);
    chk("nf.cnt", 128'(bus1.char_count), 128'd16);
    chk("nf.rdy", 128'(bus1.message_ready), 128'd0);
    chk("nf.msg", bus1.message_out, {16{8'h20}});
    send(1'b1, 8'h5A);
    chk("nf.ent", 128'(bus1.message_ready), 128'd1);
    done(1'b1);
    chk("nf.sent", 128'(bus1.char_count), 128'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("nf.strobes", 128'(n_str1), 128'd16);
    chk("sb.empty", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
